mem_port_arbiter: RTL

Shares the data port (port 2) of the multiport RAM unit between two requesters: the CPU load/store unit (LSU) and the debug/DMA engine (DBG).
- Arbitrates between them and issues one access at a time.
- Tracks the RAM's multi-cycle read and read-modify-write timing.
- Returns a completion pulse and read data to the owner.
- Bounds back-to-back data grants so instruction fetch is never starved.

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_arb_rr2.sv | 15 +
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the RAM data-port arbiter.
package mem_port_arbiter_pkg;
  typedef enum logic [2:0] {MM_BYTE, MM_BYTEU, MM_HALF, MM_HALFU, MM_WORD} mem_mode;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_arb_state;
  typedef enum logic {REQ_LSU, REQ_DBG} mem_req_id;
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    mem_mode     mode;
  } mem_req;
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: 2-way round-robin or fixed-priority pick (req[0]=LSU, req[1]=DBG).
module mem_arb_rr2
  import mem_port_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] req,
  input  mem_req_id  last,
  output logic       any,
  output mem_req_id  pick
);
  assign any  = |req;
  assign pick = (req == 2'b11) ? ((ROUND_ROBIN && last == REQ_LSU) ? REQ_DBG : REQ_LSU)
                               : (req[1] ? REQ_DBG : REQ_LSU);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares RAM port 2 between the LSU and the debug/DMA engine,
// tracking read/write latency and forcing a fetch slot after MAX_BURST grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WR_CYCLES   = 2,
  parameter int RD_TIMEOUT  = 15,
  parameter int MAX_BURST   = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_adr,
  input  logic [31:0] lsu_wdata,
  input  mem_mode     lsu_mode,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_wdata,
  input  mem_mode     dbg_mode,
  output logic [31:0] dbg_rdata,
  output logic        dbg_done,
  input  logic        ram_idle,
  output logic        port2en,
  output logic        port2WEn,
  output logic [31:0] port2adr,
  output logic [31:0] port2i,
  output mem_mode     memMode,
  input  logic [31:0] port2o,
  input  logic        port2avail,
  output logic        err
);
  localparam int WW = $clog2(WR_CYCLES + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  mem_arb_state   state_q, state_d;
  mem_req_id      owner_q, owner_d, last_q, last_d, pick;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic           err_q, err_d, any, grant, done;
  logic [31:0]    rdata;
  mem_req         win;

  mem_arb_rr2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .req  ({dbg_req, lsu_req}),
    .last (last_q),
    .any  (any),
    .pick (pick)
  );

  assign win   = (pick == REQ_DBG) ? '{dbg_we, dbg_adr, dbg_wdata, dbg_mode}
                                   : '{lsu_we, lsu_adr, lsu_wdata, lsu_mode};
  // Reset gates the grant so a held request cannot reach the RAM while it is being reset.
  assign grant = state_q == IDLE && any && ram_idle && !reset && burst_q < BW'(MAX_BURST);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    burst_d  = burst_q;
    err_d    = err_q;
    port2en  = 1'b0;
    port2WEn = 1'b0;
    port2adr = '0;
    port2i   = '0;
    memMode  = MM_BYTE;
    done     = 1'b0;
    rdata    = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          port2en  = 1'b1;
          port2WEn = win.we;
          port2adr = win.adr;
          port2i   = win.wdata;
          memMode  = win.mode;
          owner_d  = pick;
          last_d   = pick;
          burst_d  = burst_q + BW'(1);
          state_d  = win.we ? WR_WAIT : RD_WAIT;
          wcnt_d   = WW'(WR_CYCLES);
          tcnt_d   = '0;
        end else begin
          burst_d  = '0;
        end
      end
      RD_WAIT: begin
        if (port2avail) begin
          done    = 1'b1;
          rdata   = port2o;
          state_d = IDLE;
        end else if (tcnt_q == TW'(RD_TIMEOUT)) begin
          done    = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
        end
      end
      WR_WAIT: begin
        wcnt_d  = wcnt_q - WW'(1);
        done    = wcnt_q == WW'(1);
        state_d = done ? IDLE : WR_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= REQ_LSU;
      last_q  <= REQ_DBG;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  assign lsu_done  = done && owner_q == REQ_LSU;
  assign dbg_done  = done && owner_q == REQ_DBG;
  assign lsu_rdata = lsu_done ? rdata : '0;
  assign dbg_rdata = dbg_done ? rdata : '0;
  assign err       = err_q;
endmodule
